// File: rtl/ifft_eight_seq_if.sv
// Stream bundle for ifft_eight_seq: spectrum-bin input channel and time-sample output channel.
// The slave modport is the IFFT side; the master modport is the producer/consumer side.
interface ifft_eight_seq_if #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 22
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_re;
  logic signed [IN_W-1:0]  in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic [2:0]              out_idx;
  logic                    out_last;
  logic                    busy;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );
endinterface

// File: rtl/ifft_eight_seq.sv
// Sequential 8-point radix-2 DIF inverse FFT, one butterfly stage per cycle, output scaled by 1/8.
// Define IFFT_SAT_EN to clamp outputs to the OUT_W range; otherwise outputs wrap to the low OUT_W bits.
module ifft_eight_seq #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 22,
  parameter int TW_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  ifft_eight_seq_if.slave   bus
);

  localparam int IW = IN_W + 1;
  localparam int PW = TW_W + IW + 1;
  localparam logic signed [TW_W-1:0] TWC = TW_W'($rtoi(0.70710678 * (2.0 ** (TW_W - 1))));

  typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, UNLOAD} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [2:0]            r_cnt;
  logic signed [IW-1:0]  r_bufRe [8];
  logic signed [IW-1:0]  r_bufIm [8];
  logic signed [IW-1:0]  w_stRe [8];
  logic signed [IW-1:0]  w_stIm [8];
  logic                  r_outValid;
  logic signed [OUT_W-1:0] r_outRe;
  logic signed [OUT_W-1:0] r_outIm;
  logic [2:0]            r_outIdx;
  logic                  r_outLast;
  logic                  w_inReady;
  logic                  w_busy;
  logic                  w_inFire;
  logic                  w_outFire;
  logic [2:0]            w_lo;
  logic [2:0]            w_hi;
  logic [1:0]            w_tw;
  logic [1:0]            w_bb;
  logic signed [IW-1:0]  w_dRe;
  logic signed [IW-1:0]  w_dIm;

  function automatic logic signed [IW-1:0] halfSum(input logic signed [IW-1:0] a,
                                                   input logic signed [IW-1:0] b);
    logic signed [IW:0] s;
    s = {a[IW-1], a} + {b[IW-1], b};
    return s[IW:1];
  endfunction

  function automatic logic signed [IW-1:0] halfDiff(input logic signed [IW-1:0] a,
                                                    input logic signed [IW-1:0] b);
    logic signed [IW:0] s;
    s = {a[IW-1], a} - {b[IW-1], b};
    return s[IW:1];
  endfunction

  // (+/-)0.7071*x (+/-) 0.7071*y, products summed at full width before the Q(TW_W-1) rescale
  function automatic logic signed [IW-1:0] mac707(input logic signed [IW-1:0] x,
                                                  input logic signed [IW-1:0] y,
                                                  input logic negX,
                                                  input logic negY);
    logic signed [PW-1:0] px;
    logic signed [PW-1:0] py;
    logic signed [PW-1:0] acc;
    px = PW'(x) * PW'(TWC);
    py = PW'(y) * PW'(TWC);
    if (negX) px = -px;
    if (negY) py = -py;
    acc = px + py;
    return IW'(acc >>> (TW_W - 1));
  endfunction

  function automatic logic [2:0] bitRev(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  function automatic logic signed [OUT_W-1:0] fitOut(input logic signed [IW-1:0] v);
`ifdef IFFT_SAT_EN
    logic signed [IW-1:0] maxV;
    logic signed [IW-1:0] minV;
    maxV = IW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    minV = IW'(-(64'sd1 <<< (OUT_W - 1)));
    if (v > maxV) return maxV[OUT_W-1:0];
    if (v < minV) return minV[OUT_W-1:0];
    return v[OUT_W-1:0];
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  assign w_inFire  = bus.in_valid & w_inReady;
  assign w_outFire = r_outValid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      LOAD: begin
        w_inReady = 1'b1;
        w_busy    = 1'b0;
        if (w_inFire && r_cnt == 3'd7) w_nextState = ST1;
      end
      ST1:    w_nextState = ST2;
      ST2:    w_nextState = ST3;
      ST3:    w_nextState = UNLOAD;
      UNLOAD: if (w_outFire && r_outIdx == 3'd7) w_nextState = LOAD;
      default: w_nextState = LOAD;
    endcase
  end

  // Four butterflies of the current stage; the pair spacing and twiddle index depend on the stage
  always_comb begin
    w_stRe = r_bufRe;
    w_stIm = r_bufIm;
    w_lo   = '0;
    w_hi   = '0;
    w_tw   = '0;
    w_bb   = '0;
    w_dRe  = '0;
    w_dIm  = '0;
    for (int b = 0; b < 4; b++) begin
      w_bb = 2'(b);
      case (r_state)
        ST1: begin
          w_lo = {1'b0, w_bb};
          w_hi = {1'b1, w_bb};
          w_tw = w_bb;
        end
        ST2: begin
          w_lo = {w_bb[1], 1'b0, w_bb[0]};
          w_hi = {w_bb[1], 1'b1, w_bb[0]};
          w_tw = {w_bb[0], 1'b0};
        end
        default: begin
          w_lo = {w_bb, 1'b0};
          w_hi = {w_bb, 1'b1};
          w_tw = 2'd0;
        end
      endcase
      w_stRe[w_lo] = halfSum(r_bufRe[w_lo], r_bufRe[w_hi]);
      w_stIm[w_lo] = halfSum(r_bufIm[w_lo], r_bufIm[w_hi]);
      w_dRe = halfDiff(r_bufRe[w_lo], r_bufRe[w_hi]);
      w_dIm = halfDiff(r_bufIm[w_lo], r_bufIm[w_hi]);
      case (w_tw)
        2'd1: begin
          w_stRe[w_hi] = mac707(w_dRe, w_dIm, 1'b0, 1'b1);
          w_stIm[w_hi] = mac707(w_dRe, w_dIm, 1'b0, 1'b0);
        end
        2'd2: begin
          w_stRe[w_hi] = -w_dIm;
          w_stIm[w_hi] = w_dRe;
        end
        2'd3: begin
          w_stRe[w_hi] = mac707(w_dRe, w_dIm, 1'b1, 1'b1);
          w_stIm[w_hi] = mac707(w_dRe, w_dIm, 1'b0, 1'b1);
        end
        default: begin
          w_stRe[w_hi] = w_dRe;
          w_stIm[w_hi] = w_dIm;
        end
      endcase
    end
  end

  // Sample buffer carries no reset: a partial frame is simply overwritten by the next load
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      if (w_inFire) begin
        r_bufRe[r_cnt] <= IW'(bus.in_re);
        r_bufIm[r_cnt] <= IW'(bus.in_im);
      end
    end else if (r_state == ST1 || r_state == ST2 || r_state == ST3) begin
      r_bufRe <= w_stRe;
      r_bufIm <= w_stIm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_outRe    <= '0;
      r_outIm    <= '0;
      r_outIdx   <= '0;
      r_outLast  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: if (w_inFire) r_cnt <= r_cnt + 3'd1;
        ST3: begin
          r_outValid <= 1'b1;
          r_outIdx   <= 3'd0;
          r_outLast  <= 1'b0;
          r_outRe    <= fitOut(w_stRe[0]);
          r_outIm    <= fitOut(w_stIm[0]);
        end
        UNLOAD: begin
          if (w_outFire) begin
            if (r_outIdx == 3'd7) begin
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_outIdx   <= 3'd0;
            end else begin
              r_outIdx  <= r_outIdx + 3'd1;
              r_outLast <= (r_outIdx == 3'd6);
              r_outRe   <= fitOut(r_bufRe[bitRev(r_outIdx + 3'd1)]);
              r_outIm   <= fitOut(r_bufIm[bitRev(r_outIdx + 3'd1)]);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_outValid;
  assign bus.out_re    = r_outRe;
  assign bus.out_im    = r_outIm;
  assign bus.out_idx   = r_outIdx;
  assign bus.out_last  = r_outLast;

endmodule

// File: doc/ifft_eight_seq.md
Name: ifft_eight_seq

Overview:
- Sequential 8-point radix-2 DIF inverse FFT. It is the receive-side counterpart of the 8-point forward FFT and returns spectrum frames to the time domain.
- It accepts one complex spectrum bin per cycle over a valid/ready stream and computes three butterfly stages, one stage per cycle, with four butterflies in parallel.
- It emits 8 time-domain samples in natural order, scaled by 1/8.
- It sits directly downstream of the forward FFT (or its channel path) and reconstructs x[n] ≈ (1/8)·Σ X[k]·W8^(-nk).

Parameters:
- IN_W, 37, signed input width (matches forward FFT output width).
- OUT_W, 22, signed output width (matches forward FFT input width).
- TW_W, 8, signed twiddle width, Q(TW_W-1); 0.7071 encoded as 90.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input bin valid
- in_ready  out  1  block can accept a bin
- in_re  in  IN_W  bin real part, signed, bin order k=0..7
- in_im  in  IN_W  bin imaginary part, signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample
- out_re  out  OUT_W  sample real part, signed
- out_im  out  OUT_W  sample imaginary part, signed
- out_idx  out  3  time index n of the current sample
- out_last  out  1  high with n=7
- busy  out  1  high in any state other than LOAD

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high on rst.
- Reset values: state=LOAD, load counter=0, in_ready=1, out_valid=0, out_re/out_im=0, out_idx=0, out_last=0, busy=0. Internal buffer contents are don't-care.
- Reset mid-operation: rst=1 in any state aborts the frame. A partial frame is discarded and no output is produced.
- Internal datapath width: IW = IN_W+1, signed. All arithmetic is two's complement.
- FSM states: LOAD, ST1, ST2, ST3, UNLOAD.
- LOAD:
  - in_ready=1; a handshake is in_valid & in_ready.
  - Each handshake writes buf[cnt] and increments cnt.
  - On the handshake with cnt=7: cnt wraps to 0 and the FSM goes to ST1.
  - in_valid=0 holds cnt with no write; gaps between bins are allowed.
- ST1 (pairs (k, k+4), k=0..3):
  - a'=(a+b)>>>1 and d=(a-b)>>>1.
  - b' = d·conj(W8^k), i.e. d·W8^(-k): k=0 → d; k=1 → d·(90+j90)>>>7; k=2 → j·d (exact swap/negate); k=3 → d·(-90+j90)>>>7.
  - Multiplier products are TW_W+IW bits wide, then arithmetic shift right TW_W-1.
- ST2 (pairs (k, k+2) within each half):
  - Same halving.
  - Twiddle 1 for the lower index, j for the upper index (exact, no multiplier).
- ST3 (pairs (k, k+1)):
  - Sum/difference with halving; no twiddle.
- Shift convention: every >>>1 is arithmetic with truncation toward minus infinity. Total scale is 1/8.
- After ST3: buffer holds bit-reversed order; FSM goes to UNLOAD with rd=0.
- UNLOAD:
  - out_valid=1, out_idx=rd, out_re/out_im=buf[bitrev(rd)] resized to OUT_W (see Optional Feature), out_last=(rd==7).
  - rd increments only on out_valid & out_ready.
  - The handshake at rd=7 returns the FSM to LOAD.
  - out_ready=0 holds all outputs stable.
- Latency: last input handshake at cycle T → ST1 at T+1, ST2 at T+2, ST3 at T+3, first out_valid at T+4. Minimum frame period is 8 load + 3 compute + 8 unload = 19 cycles.
- in_ready is 0 in ST1..UNLOAD. It rises the cycle after the out_last handshake, so a new frame is never loaded during unload.
- Registered outputs: out_* are registered and change only on clk. in_ready is a function of state only (no combinational path from in_valid).

Optional Feature:
- Macro: IFFT_SAT_EN.
- Defined: each output component above 2^(OUT_W-1)-1 or below -2^(OUT_W-1) is clamped to that bound.
- Undefined: each output is the low OUT_W bits of the internal value (wrap).

Test Plan:
- DC bin: X[0]=(800,0), X[1..7]=0, out_ready=1 → all 8 outputs (100,0), out_idx 0..7, out_last only at idx 7, first out_valid 4 cycles after the last in handshake.
- Flat spectrum: X[k]=(800,0) for all k → x[0]=(800,0), x[1..7]=(0,0).
- Bin 2: X[2]=(800,0), rest 0 → x[0..7] = (100,0), (0,100), (-100,0), (0,-100), (100,0), (0,100), (-100,0), (0,-100).
- Backpressure and gaps:
  - Drive in_valid with 1-cycle gaps → cnt does not advance during gaps.
  - Hold out_ready=0 for 5 cycles at rd=3 → out_re/out_im/out_idx stay stable.
  - in_ready stays 0 until the cycle after the out_last handshake.
- Overflow: X[k]=(2^30,0) for all k, defaults.
  - With IFFT_SAT_EN → x[0]=(2097151,0).
  - Without it → x[0]=(0,0).
  - In both cases x[1..7]=(0,0).
- Reset mid-frame:
  - Assert rst after 5 bins → next cycle in_ready=1, out_valid=0, cnt=0.
  - A fresh DC frame then yields eight (100,0) samples with no stale data.
